// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and the bridge state type used by the single-beat memory bridge.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Normal non-cacheable, modifiable.
    localparam logic [3:0] CACHE_DEFAULT = 4'b0010;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA
    } bridge_state_e;

    function automatic logic [2:0] axi_size(input int unsigned nbytes);
        return 3'($clog2(nbytes));
    endfunction

endpackage

// File: rtl/axi_bus.sv
// Five-channel AXI4 bus bundle with master and slave views.
interface AXI_BUS #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 2
);
    logic [ID_WIDTH-1:0]     aw_id;
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic [7:0]              aw_len;
    logic [2:0]              aw_size;
    logic [1:0]              aw_burst;
    logic                    aw_lock;
    logic [3:0]              aw_cache;
    logic [2:0]              aw_prot;
    logic [3:0]              aw_qos;
    logic                    aw_valid;
    logic                    aw_ready;

    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    w_last;
    logic                    w_valid;
    logic                    w_ready;

    logic [ID_WIDTH-1:0]     b_id;
    logic [1:0]              b_resp;
    logic                    b_valid;
    logic                    b_ready;

    logic [ID_WIDTH-1:0]     ar_id;
    logic [ADDR_WIDTH-1:0]   ar_addr;
    logic [7:0]              ar_len;
    logic [2:0]              ar_size;
    logic [1:0]              ar_burst;
    logic                    ar_lock;
    logic [3:0]              ar_cache;
    logic [2:0]              ar_prot;
    logic [3:0]              ar_qos;
    logic                    ar_valid;
    logic                    ar_ready;

    logic [ID_WIDTH-1:0]     r_id;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [1:0]              r_resp;
    logic                    r_last;
    logic                    r_valid;
    logic                    r_ready;

    modport Master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_valid,
        output r_ready
    );

    modport Slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_valid,
        output w_ready,
        output b_id, b_resp, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos, ar_valid,
        output ar_ready,
        input  r_id, r_data, r_resp, r_last, r_valid,
        output r_ready
    );

endinterface

// File: rtl/axi_mem_bridge.sv
// Core data-port to AXI4 single-beat bridge: one outstanding transaction, registered request
// and completion, independent AW/W handshakes on writes.
module axi_mem_bridge
    import axi_pkg::*;
#(
    parameter int ID_WIDTH   = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int AXI_ID     = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    data_req,
    input  logic [ADDR_WIDTH-1:0]   data_addr,
    input  logic                    data_we,
    input  logic [DATA_WIDTH/8-1:0] data_be,
    input  logic [DATA_WIDTH-1:0]   data_wdata,
    output logic                    data_gnt,
    output logic                    data_rvalid,
    output logic [DATA_WIDTH-1:0]   data_rdata,
    output logic                    data_err,
    AXI_BUS.Master                  m_axi
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    bridge_state_e           state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic                    we_reg;
    logic [STRB_WIDTH-1:0]   be_reg;
    logic [DATA_WIDTH-1:0]   wdata_reg;
    logic                    aw_done_reg, w_done_reg;
    logic                    rvalid_reg, err_reg;
    logic [DATA_WIDTH-1:0]   rdata_reg;

    logic aw_valid, w_valid, ar_valid, b_ready, r_ready;
    logic aw_hs, w_hs, resp_done;
    logic [1:0] resp_code;

    // Each write channel drops its valid independently once its own handshake is seen.
    assign aw_valid  = (state_reg == WR_ADDR_DATA) && !aw_done_reg;
    assign w_valid   = (state_reg == WR_ADDR_DATA) && !w_done_reg;
    assign ar_valid  = (state_reg == RD_ADDR);
    assign b_ready   = (state_reg == WR_RESP);
    assign r_ready   = (state_reg == RD_DATA);
    assign aw_hs     = aw_valid && m_axi.aw_ready;
    assign w_hs      = w_valid && m_axi.w_ready;
    assign resp_done = (b_ready && m_axi.b_valid) || (r_ready && m_axi.r_valid);
    assign resp_code = we_reg ? m_axi.b_resp : m_axi.r_resp;

    always_comb begin
        state_next = state_reg;
        data_gnt   = 1'b0;
        case (state_reg)
            IDLE: begin
                data_gnt = data_req && !rst;
                if (data_req) state_next = data_we ? WR_ADDR_DATA : RD_ADDR;
            end
            WR_ADDR_DATA: if ((aw_done_reg || aw_hs) && (w_done_reg || w_hs)) state_next = WR_RESP;
            WR_RESP:      if (m_axi.b_valid) state_next = IDLE;
            RD_ADDR:      if (m_axi.ar_ready) state_next = RD_DATA;
            RD_DATA:      if (m_axi.r_valid) state_next = IDLE;
            default:      state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            addr_reg    <= '0;
            we_reg      <= 1'b0;
            be_reg      <= '0;
            wdata_reg   <= '0;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
            rvalid_reg  <= 1'b0;
            err_reg     <= 1'b0;
            rdata_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (data_gnt) begin
                addr_reg  <= data_addr;
                we_reg    <= data_we;
                be_reg    <= data_be;
                wdata_reg <= data_wdata;
            end
            if (state_reg == WR_ADDR_DATA) begin
                if (aw_hs) aw_done_reg <= 1'b1;
                if (w_hs)  w_done_reg  <= 1'b1;
            end else begin
                aw_done_reg <= 1'b0;
                w_done_reg  <= 1'b0;
            end
            rvalid_reg <= resp_done;
            err_reg    <= resp_done && (resp_code != RESP_OKAY);
            if (r_ready && m_axi.r_valid) rdata_reg <= m_axi.r_data;
        end
    end

    assign data_rvalid = rvalid_reg;
    assign data_err    = err_reg;
    assign data_rdata  = rdata_reg;

    assign m_axi.aw_id    = ID_WIDTH'(AXI_ID);
    assign m_axi.aw_addr  = addr_reg;
    assign m_axi.aw_len   = 8'd0;
    assign m_axi.aw_size  = axi_size(STRB_WIDTH);
    assign m_axi.aw_burst = BURST_INCR;
    assign m_axi.aw_lock  = 1'b0;
    assign m_axi.aw_cache = CACHE_DEFAULT;
    assign m_axi.aw_prot  = 3'b000;
    assign m_axi.aw_qos   = 4'd0;
    assign m_axi.aw_valid = aw_valid;

    assign m_axi.w_data   = wdata_reg;
    assign m_axi.w_strb   = be_reg;
    assign m_axi.w_last   = w_valid;
    assign m_axi.w_valid  = w_valid;
    assign m_axi.b_ready  = b_ready;

    assign m_axi.ar_id    = ID_WIDTH'(AXI_ID);
    assign m_axi.ar_addr  = addr_reg;
    assign m_axi.ar_len   = 8'd0;
    assign m_axi.ar_size  = axi_size(STRB_WIDTH);
    assign m_axi.ar_burst = BURST_INCR;
    assign m_axi.ar_lock  = 1'b0;
    assign m_axi.ar_cache = CACHE_DEFAULT;
    assign m_axi.ar_prot  = 3'b000;
    assign m_axi.ar_qos   = 4'd0;
    assign m_axi.ar_valid = ar_valid;
    assign m_axi.r_ready  = r_ready;

    // IDs and r_last carry no information with a single outstanding single-beat transaction.
    logic unused_resp_fields;
    assign unused_resp_fields = ^{m_axi.b_id, m_axi.r_id, m_axi.r_last};

endmodule

// File: tb/tb_axi_mem_bridge.sv
// Directed and random-stall checks of axi_mem_bridge against hand-derived expectations.
module tb_axi_mem_bridge;
    import axi_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        data_req;
    logic [31:0] data_addr;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_wdata;
    logic        data_gnt;
    logic        data_rvalid;
    logic [31:0] data_rdata;
    logic        data_err;

    AXI_BUS #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(2)) axi_if ();

    axi_mem_bridge #(
        .ID_WIDTH(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .AXI_ID(0)
    ) dut (
        .clk(clk), .rst(rst),
        .data_req(data_req), .data_addr(data_addr), .data_we(data_we),
        .data_be(data_be), .data_wdata(data_wdata),
        .data_gnt(data_gnt), .data_rvalid(data_rvalid),
        .data_rdata(data_rdata), .data_err(data_err),
        .m_axi(axi_if)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int pay_err = 0;
    int stab_viol = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Valid/payload stability and mutual exclusion of read and write channels.
    logic        p_rst = 1'b1;
    logic        p_awv = 1'b0, p_awr = 1'b0, p_wv = 1'b0, p_wr = 1'b0, p_arv = 1'b0, p_arr = 1'b0;
    logic [31:0] p_awa = '0, p_wd = '0, p_ara = '0;
    logic [3:0]  p_ws = '0;
    always @(posedge clk) begin : mon
        logic bad;
        bad = 1'b0;
        if (!p_rst) begin
            if (p_awv && !p_awr && !(axi_if.aw_valid && axi_if.aw_addr == p_awa)) bad = 1'b1;
            if (p_wv && !p_wr && !(axi_if.w_valid && axi_if.w_data == p_wd && axi_if.w_strb == p_ws)) bad = 1'b1;
            if (p_arv && !p_arr && !(axi_if.ar_valid && axi_if.ar_addr == p_ara)) bad = 1'b1;
        end
        if ((axi_if.aw_valid || axi_if.w_valid) && axi_if.ar_valid) bad = 1'b1;
        if (bad) stab_viol <= stab_viol + 1;
        p_rst <= rst;
        p_awv <= axi_if.aw_valid; p_awr <= axi_if.aw_ready; p_awa <= axi_if.aw_addr;
        p_wv  <= axi_if.w_valid;  p_wr  <= axi_if.w_ready;  p_wd  <= axi_if.w_data;
        p_ws  <= axi_if.w_strb;
        p_arv <= axi_if.ar_valid; p_arr <= axi_if.ar_ready; p_ara <= axi_if.ar_addr;
    end

    task automatic read_txn(input logic [31:0] addr, input logic [31:0] rd,
                            input logic [1:0] resp, input logic exp_err);
        data_req = 1'b1; data_we = 1'b0; data_addr = addr; data_be = 4'hF;
        #1;
        check_val("rd_gnt", data_gnt, 1'b1);
        step();
        data_req = 1'b0; data_addr = 32'hFFFF_FFFF;
        #1;
        check_val("rd_gnt_busy", data_gnt, 1'b0);
        check_val("rd_arvalid", axi_if.ar_valid, 1'b1);
        check_val("rd_araddr", axi_if.ar_addr, addr);
        check_val("rd_arlen", axi_if.ar_len, 8'd0);
        check_val("rd_arsize", axi_if.ar_size, 3'd2);
        check_val("rd_arburst", axi_if.ar_burst, 2'b01);
        check_val("rd_arcache", axi_if.ar_cache, 4'b0010);
        check_val("rd_arfixed", {axi_if.ar_id, axi_if.ar_lock, axi_if.ar_prot, axi_if.ar_qos}, 10'd0);
        axi_if.ar_ready = 1'b1;
        step();
        axi_if.ar_ready = 1'b0;
        check_val("rd_arvalid_drop", axi_if.ar_valid, 1'b0);
        check_val("rd_rready", axi_if.r_ready, 1'b1);
        check_val("rd_rvalid_early", data_rvalid, 1'b0);
        axi_if.r_valid = 1'b1; axi_if.r_data = rd; axi_if.r_resp = resp;
        step();
        axi_if.r_valid = 1'b0; axi_if.r_data = '0; axi_if.r_resp = 2'b00;
        check_val("rd_rvalid", data_rvalid, 1'b1);
        check_val("rd_rdata", data_rdata, rd);
        check_val("rd_err", data_err, exp_err);
        $display("[TB] read  addr=0x%08h data=0x%08h resp=%0d err=%0b", addr, data_rdata, resp, data_err);
        step();
        check_val("rd_rvalid_pulse", data_rvalid, 1'b0);
        check_val("rd_rdata_hold", data_rdata, rd);
    endtask

    initial begin
        rst = 1'b1; data_req = 1'b1; data_addr = 32'h55; data_we = 1'b0;
        data_be = 4'h0; data_wdata = '0;
        axi_if.aw_ready = 1'b0; axi_if.w_ready = 1'b0; axi_if.ar_ready = 1'b0;
        axi_if.b_valid = 1'b0; axi_if.b_resp = 2'b00; axi_if.b_id = 2'd0;
        axi_if.r_valid = 1'b0; axi_if.r_data = '0; axi_if.r_resp = 2'b00;
        axi_if.r_id = 2'd0; axi_if.r_last = 1'b1;
        step(); step();
        check_val("reset_gnt", data_gnt, 1'b0);
        check_val("reset_valids", {axi_if.aw_valid, axi_if.w_valid, axi_if.ar_valid,
                                   axi_if.b_ready, axi_if.r_ready}, 5'd0);
        check_val("reset_rvalid", data_rvalid, 1'b0);
        check_val("reset_err", data_err, 1'b0);
        check_val("reset_rdata", data_rdata, 32'd0);
        rst = 1'b0; data_req = 1'b0;
        step();

        // Zero-wait read, then a read answered with SLVERR.
        read_txn(32'h0000_1000, 32'hDEAD_BEEF, RESP_OKAY, 1'b0);
        read_txn(32'h0000_1040, 32'h0BAD_F00D, RESP_SLVERR, 1'b1);

        // Write with W accepted immediately and AW held off for four cycles.
        data_req = 1'b1; data_we = 1'b1; data_addr = 32'h2000;
        data_wdata = 32'hA5A5_A5A5; data_be = 4'b0011;
        #1;
        check_val("wr_gnt", data_gnt, 1'b1);
        step();
        data_req = 1'b0; data_wdata = '0; data_be = '0;
        check_val("wr_awvalid", axi_if.aw_valid, 1'b1);
        check_val("wr_wvalid", axi_if.w_valid, 1'b1);
        check_val("wr_awaddr", axi_if.aw_addr, 32'h2000);
        check_val("wr_wdata", axi_if.w_data, 32'hA5A5_A5A5);
        check_val("wr_wstrb", axi_if.w_strb, 4'b0011);
        check_val("wr_wlast", axi_if.w_last, 1'b1);
        check_val("wr_awfixed", {axi_if.aw_len, axi_if.aw_size, axi_if.aw_burst, axi_if.aw_cache},
                  {8'd0, 3'd2, 2'b01, 4'b0010});
        axi_if.w_ready = 1'b1;
        step();
        axi_if.w_ready = 1'b0;
        check_val("wr_wvalid_drop", axi_if.w_valid, 1'b0);
        check_val("wr_aw_hold", axi_if.aw_valid, 1'b1);
        check_val("wr_bready_early", axi_if.b_ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("wr_aw_wait", {axi_if.aw_valid, axi_if.w_valid, axi_if.b_ready}, 3'b100);
        end
        axi_if.aw_ready = 1'b1;
        step();
        axi_if.aw_ready = 1'b0;
        check_val("wr_awvalid_drop", axi_if.aw_valid, 1'b0);
        check_val("wr_bready", axi_if.b_ready, 1'b1);
        axi_if.b_valid = 1'b1; axi_if.b_resp = RESP_OKAY;
        step();
        axi_if.b_valid = 1'b0;
        check_val("wr_rvalid", data_rvalid, 1'b1);
        check_val("wr_err", data_err, 1'b0);
        $display("[TB] write addr=0x2000 data=0xa5a5a5a5 be=0011 err=%0b", data_err);
        step();
        check_val("wr_rvalid_pulse", data_rvalid, 1'b0);

        // Back-to-back: write granted, read request held until the write completes.
        data_req = 1'b1; data_we = 1'b1; data_addr = 32'h3000;
        data_wdata = 32'h1234_5678; data_be = 4'hF;
        #1;
        check_val("b2b_gnt1", data_gnt, 1'b1);
        step();
        data_we = 1'b0; data_addr = 32'h4000;
        #1;
        check_val("b2b_busy_w", {data_gnt, axi_if.ar_valid, axi_if.aw_valid, axi_if.w_valid}, 4'b0011);
        axi_if.aw_ready = 1'b1; axi_if.w_ready = 1'b1;
        step();
        axi_if.aw_ready = 1'b0; axi_if.w_ready = 1'b0;
        check_val("b2b_busy_b", {data_gnt, axi_if.ar_valid, axi_if.aw_valid, axi_if.w_valid, axi_if.b_ready},
                  5'b00001);
        axi_if.b_valid = 1'b1; axi_if.b_resp = RESP_OKAY;
        step();
        axi_if.b_valid = 1'b0;
        check_val("b2b_rvalid1", data_rvalid, 1'b1);
        check_val("b2b_gnt2", data_gnt, 1'b1);
        check_val("b2b_noarv", axi_if.ar_valid, 1'b0);
        step();
        data_req = 1'b0;
        check_val("b2b_rd", {axi_if.ar_valid, axi_if.aw_valid, axi_if.w_valid}, 3'b100);
        check_val("b2b_araddr", axi_if.ar_addr, 32'h4000);
        axi_if.ar_ready = 1'b1;
        step();
        axi_if.ar_ready = 1'b0;
        axi_if.r_valid = 1'b1; axi_if.r_data = 32'hCAFE_F00D; axi_if.r_resp = RESP_OKAY;
        step();
        axi_if.r_valid = 1'b0;
        check_val("b2b_rvalid2", data_rvalid, 1'b1);
        check_val("b2b_rdata", data_rdata, 32'hCAFE_F00D);
        $display("[TB] b2b   write 0x3000 then read 0x4000 data=0x%08h", data_rdata);
        step();

        // Reset while a write response is being offered.
        data_req = 1'b1; data_we = 1'b1; data_addr = 32'h5000;
        data_wdata = 32'h0F0F_0F0F; data_be = 4'hF;
        step();
        data_req = 1'b0;
        axi_if.aw_ready = 1'b1; axi_if.w_ready = 1'b1;
        step();
        axi_if.aw_ready = 1'b0; axi_if.w_ready = 1'b0;
        check_val("rst_pre_bready", axi_if.b_ready, 1'b1);
        axi_if.b_valid = 1'b1; rst = 1'b1;
        step();
        axi_if.b_valid = 1'b0;
        check_val("rst_bready", axi_if.b_ready, 1'b0);
        check_val("rst_rvalid", data_rvalid, 1'b0);
        rst = 1'b0;
        step();
        check_val("rst_rvalid_after", data_rvalid, 1'b0);
        $display("[TB] reset during write response, transaction abandoned");
        read_txn(32'h0000_6000, 32'h1357_9BDF, RESP_OKAY, 1'b0);

        // Random-stall traffic, back-to-back where the bridge allows.
        for (int t = 0; t < 1000; t++) begin
            logic        we;
            logic [31:0] a, wd, rd;
            logic [3:0]  be;
            logic [1:0]  resp;
            logic        done;
            int          cyc;
            we = 1'($urandom_range(0, 1)); a = $urandom; wd = $urandom; rd = $urandom;
            be = 4'($urandom); resp = 2'($urandom_range(0, 3));
            data_req = 1'b1; data_we = we; data_addr = a; data_wdata = wd; data_be = be;
            #1;
            check_val("rnd_gnt", data_gnt, 1'b1);
            step();
            data_req = 1'b0; data_addr = $urandom; data_wdata = $urandom; data_be = 4'($urandom);
            done = 1'b0; cyc = 0;
            while (!done && cyc < 64) begin
                axi_if.aw_ready = ($urandom_range(0, 2) == 0);
                axi_if.w_ready  = ($urandom_range(0, 2) == 0);
                axi_if.ar_ready = ($urandom_range(0, 2) == 0);
                axi_if.b_valid  = axi_if.b_ready && ($urandom_range(0, 1) == 0);
                axi_if.b_resp   = resp;
                axi_if.r_valid  = axi_if.r_ready && ($urandom_range(0, 1) == 0);
                axi_if.r_data   = rd;
                axi_if.r_resp   = resp;
                if (axi_if.aw_valid && axi_if.aw_addr !== a) pay_err++;
                if (axi_if.ar_valid && axi_if.ar_addr !== a) pay_err++;
                if (axi_if.w_valid && (axi_if.w_data !== wd || axi_if.w_strb !== be || axi_if.w_last !== 1'b1))
                    pay_err++;
                step();
                cyc++;
                done = data_rvalid;
            end
            axi_if.aw_ready = 1'b0; axi_if.w_ready = 1'b0; axi_if.ar_ready = 1'b0;
            axi_if.b_valid = 1'b0; axi_if.r_valid = 1'b0;
            check_val("rnd_done", done, 1'b1);
            check_val("rnd_err", data_err, resp != 2'b00);
            if (!we) check_val("rnd_rdata", data_rdata, rd);
            $display("[TB] rnd %0d %s addr=0x%08h resp=%0d cycles=%0d", t, we ? "wr" : "rd", a, resp, cyc);
        end
        step();
        check_val("rnd_payload", pay_err, 0);
        check_val("valid_stability", stab_viol, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
